// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM state encoding for the 16-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N          = 16;
  localparam int IDW        = 4;
  localparam int TMO_CYCLES = 255;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter16_pick.sv
// Combinational rotating priority picker: first set req bit at or after ptr, wrapping 15->0.
// No registers, no backpressure; found=0 when req is empty.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [N-1:0]   rot;
  logic [IDW-1:0] off;

  // rot[j] is the request at position ptr+j, so bit 0 carries the highest priority.
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[ptr + IDW'(j)];
    end
  end

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = IDW'(j);
      end
    end
  end

  assign idx = ptr + off;

endmodule

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter holding each grant until done or req drop; grant one cycle after req.
// Registered outputs, one idle cycle between owners; RR_ARB_TIMEOUT_EN adds a grant watchdog.
module rr_arbiter16 #(
  parameter int N          = rr_arb_pkg::N,
  parameter int IDW        = rr_arb_pkg::IDW,
  parameter int TMO_CYCLES = rr_arb_pkg::TMO_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           timeout
);

  import rr_arb_pkg::*;

  if (N != 16 || IDW != 4 || TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_cfg
    $error("rr_arbiter16: unsupported parameter set");
  end

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [N-1:0]   grant_nxt;
  logic [IDW-1:0] grant_id_nxt;
  logic           grant_valid_nxt;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           owner_release;
  logic           wd_hit;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // done and a dropped owner request on the same edge are one release.
  assign owner_release = done | ~req[grant_id];

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt, wd_cnt_nxt;
  logic       timeout_nxt;

  assign wd_hit = (wd_cnt == 8'(TMO_CYCLES - 1));
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    grant_nxt       = grant;
    grant_id_nxt    = grant_id;
    grant_valid_nxt = grant_valid;
`ifdef RR_ARB_TIMEOUT_EN
    wd_cnt_nxt  = wd_cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt       = ST_GRANT;
          grant_nxt       = N'(1) << pick_idx;
          grant_id_nxt    = pick_idx;
          grant_valid_nxt = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          wd_cnt_nxt = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (owner_release || wd_hit) begin
          state_nxt       = ST_IDLE;
          grant_nxt       = '0;
          grant_id_nxt    = '0;
          grant_valid_nxt = 1'b0;
          ptr_nxt         = grant_id + IDW'(1);
`ifdef RR_ARB_TIMEOUT_EN
          timeout_nxt = ~owner_release;
        end else begin
          wd_cnt_nxt = wd_cnt + 8'd1;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant       <= grant_nxt;
      grant_id    <= grant_id_nxt;
      grant_valid <= grant_valid_nxt;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      wd_cnt  <= wd_cnt_nxt;
      timeout <= timeout_nxt;
    end
  end
`endif

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter that shares one resource among 16 requesters. Each requester raises a bit of a 16-bit request vector; the block grants exactly one requester at a time. It holds the grant until that requester releases it, then rotates priority. It drives both a one-hot grant vector and its 4-bit binary index, so downstream muxes can select the owner directly.

## Interface
Parameters:
- N, 16, number of requesters; fixed at 16, must be a power of two.
- IDW, 4, width of the grant index; equals log2(N).
- TMO_CYCLES, 255, grant watchdog limit in cycles (1..255); used only with RR_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; one clock domain only.
- req  input  N  request vector; bit i = requester i wants the resource.
- done  input  1  release strobe from the current owner; sampled only in GRANT.
- grant  output  N  one-hot grant, registered; all zero when no owner.
- grant_id  output  IDW  binary index of the owner; 0 when no owner.
- grant_valid  output  1  high while grant is non-zero.
- timeout  output  1  one-cycle pulse when the watchdog forces a release; tied 0 without the macro.

## Operation
- State machine has two states, IDLE and GRANT. Reset enters IDLE.
- Priority pointer ptr (IDW bits) gives the first index searched. Reset value of ptr is 0.
- IDLE behaviour:
  - If req is non-zero, select the first set bit scanning ptr, ptr+1, … with wrap 15→0.
  - Load grant, grant_id and grant_valid from that selection, then go to GRANT.
  - If req is zero, remain in IDLE with all outputs zero.
- GRANT behaviour:
  - Hold the owner until done=1 or req[grant_id]=0, whichever comes first. Both at once count as a single release.
  - On release, clear grant, grant_id and grant_valid.
  - Set ptr = grant_id+1 mod 16, so index 15 wraps to 0.
  - Return to IDLE.
- Changes on non-owner req bits during GRANT are ignored.
- done asserted in IDLE is ignored.
- Outputs are always consistent: grant = 1<<grant_id when grant_valid=1; grant=0 and grant_id=0 otherwise.
- Reset values: grant=0, grant_id=0, grant_valid=0, timeout=0, ptr=0, watchdog count=0.
- Reset asserted mid-grant clears every output asynchronously, with no release handshake.

## Timing
- Grant latency: req sampled at edge k in IDLE gives grant valid after edge k (visible in cycle k+1).
- Release: done seen at edge m clears grant after edge m. The FSM is in IDLE during cycle m+1.
  - The next grant is sampled at edge m+1.
  - This forces a minimum one-cycle gap between owners; there are no back-to-back grants.
- A grant lasts at least one cycle, even if done is already high on the first GRANT cycle.
- All outputs are registered; there is no combinational path from req or done to any output.

## Configuration
- Macro: RR_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit watchdog counter clears on entry to GRANT and increments on every GRANT cycle.
  - When the count reaches TMO_CYCLES-1 with no release, the next edge forces a release. That release is identical to a normal one, including the ptr advance.
  - timeout pulses high for exactly that one cycle.
  - A normal release and the limit reached on the same edge count as a normal release; timeout stays 0.
- When undefined:
  - The counter logic is absent and timeout is constant 0.
  - Grants are held indefinitely until released.

## Structure
- Package rr_arb_pkg holds:
  - constants N=16, IDW=4 and the default TMO_CYCLES;
  - the FSM state enum with values ST_IDLE and ST_GRANT.
- One sub-module, rr_pick: a combinational rotating priority picker.
  - Inputs: req and ptr.
  - Outputs: a found flag and a 4-bit index.
  - The top level does the registering and computes the one-hot grant as 1<<index.

## Test plan
- Reset then req=16'h0000 for 10 cycles → grant_valid stays 0, grant=0, grant_id=0.
- req=16'h0021 from reset (ptr=0) → grant=16'h0001 and grant_id=0 one cycle later. After done, the next grant is grant_id=5 (ptr=1 skips bit 0).
- Owner 15 releases with req=16'h8001 held → ptr wraps to 0 → next grant_id=0, not 15.
- All 16 req bits held high, owner releases by done after 2 cycles each → grant_id sequence 0,1,2,…,15,0 with exactly one idle cycle between grants.
- Reset asserted mid-grant with grant_id=7 → all outputs 0 immediately. After deassert with req=16'h0080, grant_id=7 again (ptr=0).
- With RR_ARB_TIMEOUT_EN and TMO_CYCLES=4, owner 3 never releases → grant clears after 4 GRANT cycles and timeout pulses once. With req=16'h0018 held, the next grant is grant_id=4.
